medyan_birimi_seri: RTL and testbench
=====================================

// Module: medyan_birimi_seri
// PURPOSE
//  Streaming median unit for the 3x3 median filter datapath. Takes one pixel
//  per clock, collects a non-overlapping window of 9 consecutive pixels and
//  outputs their median with a one-cycle ready strobe. Sits between the
//  pixel-window feeder and the output pixel writer.
// PARAMETERS
//  PIXEL_BIT  8  pixel width in bits (default comes from `PIXEL_BIT in sabitler.vh)
//  PENCERE    9  samples per window; must be odd; median index MID=(PENCERE-1)/2
// PORTS
//  clk_i     in   1          single clock, all logic on the rising edge
//  rst_i     in   1          reset: one clock; reset is synchronous and active-high
//  sayi_i    in   PIXEL_BIT  input pixel, sampled on every rising edge while rst_i=0
//  medyan_o  out  PIXEL_BIT  median of the last complete window (registered)
//  hazir_o   out  1          one-cycle pulse: medyan_o holds a new result
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): sayac=0, all sorted slots=0, medyan_o=0, hazir_o=0.
//    A sayi_i value present during reset is ignored (may be X).
//  - No input valid signal: every edge with rst_i=0 accepts sayi_i as the next
//    window sample.
//  - State: sorted register array s[0..PENCERE-1] (ascending) + sample counter
//    sayac (0..PENCERE-1, width $clog2(PENCERE)).
//  - Insertion each accepted edge: next array = s with sayi_i inserted in
//    ascending order among the first sayac entries (parallel compare/shift,
//    one insertion per cycle); equal values insert after existing equals.
//    Arithmetic is unsigned, compares only, no width growth.
//  - On the edge accepting sample PENCERE (sayac==PENCERE-1):
//    medyan_o <= next-array[MID] (includes this last sample), hazir_o <= 1,
//    sayac <= 0, array cleared to 0. The next edge starts a new window,
//    so back-to-back windows have no bubble.
//  - Latency: hazir_o/medyan_o valid during the cycle right after the 9th sample edge.
//  - hazir_o is 1 for exactly one cycle per window, else 0; medyan_o holds its
//    value until the next window completes or reset.
//  - Counter wraps PENCERE-1 -> 0 only at window completion; never overflows.
//  - Reset mid-window: partial window discarded, no hazir_o pulse, count restarts.
//  - Reset at the same edge as the 9th sample: reset wins, no result produced.
// STRUCTURE
//  - sabitler.vh: PIXEL_BIT and the window-size constant (9); no other shared types.
//  - One sub-module, siralama_hucresi: one sorted slot holding its value; per
//    cycle it chooses keep / take input / take left neighbour, based on a
//    compare with sayi_i and the neighbour's compare flag. PENCERE instances
//    are chained in a generate loop. Counter and output registers sit in the top.
// TESTING
//  - Hold rst_i=1 for 4 cycles -> medyan_o=0, hazir_o=0 throughout.
//  - 7,7,1,1,1,2,2,9,8 -> exactly one hazir_o pulse the cycle after the 9th
//    edge, medyan_o=2.
//  - Nine samples of 5 -> 5. Samples 0..8 ascending -> 4. Samples 255..247
//    descending -> 251. Mix 0,255,0,255,0,255,0,255,255 -> 255.
//  - 18 samples back-to-back (window A = 3,1,4,1,5,9,2,6,5; window B = 9x 200)
//    -> pulses 9 cycles apart, medians 4 then 200, no cross-window mixing.
//  - Reset after 5 samples of 100, then nine samples 10..18 -> single pulse,
//    median 14; no pulse during or before the reset.
//  - Check that hazir_o never stays high for 2 consecutive cycles and that
//    medyan_o is stable between pulses.

Source files
------------

// File: rtl/medyan_birimi_seri_pkg.sv
// Shared constants for the streaming 3x3 median unit.
package medyan_birimi_seri_pkg;

    // Pixel width and samples per window (a 3x3 neighbourhood)
    localparam int PIXEL_BIT = 8;
    localparam int PENCERE   = 9;

    // Counter width and index of the median slot in the sorted array
    localparam int SAYAC_W = $clog2(PENCERE);
    localparam int MID     = (PENCERE - 1) / 2;

endpackage : medyan_birimi_seri_pkg

// File: rtl/medyan_birimi_seri_if.sv
// Pixel-in / median-out bus between the window feeder and the median unit.
//
// Handshake: there is no valid and no ready. Every rising clock edge with
// rst_i low consumes sayi_i as the next window sample, so the feeder must
// present a new pixel every cycle. hazir_o is a one-cycle strobe with no
// backpressure; medyan_o holds the latest median until the next strobe.
interface medyan_birimi_seri_if #(
    parameter int PIXEL_BIT = medyan_birimi_seri_pkg::PIXEL_BIT
);
    logic [PIXEL_BIT-1:0] sayi_i;
    logic [PIXEL_BIT-1:0] medyan_o;
    logic                 hazir_o;

    // Pixel feeder side
    modport master (output sayi_i, input medyan_o, input hazir_o);
    // Median unit side
    modport slave  (input sayi_i, output medyan_o, output hazir_o);
endinterface : medyan_birimi_seri_if

// File: rtl/medyan_birimi_seri_siralama_hucresi.sv
// One slot of the insertion-sorted array. The slot compares its value with
// the incoming pixel; an unused slot behaves as +infinity. A slot whose value
// is greater than the pixel shifts right: it takes its left neighbour's value
// if that neighbour is also greater, otherwise it takes the pixel itself.
// Strict compare places a new pixel after any existing equal values.
module siralama_hucresi
    import medyan_birimi_seri_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 temizle_i,    // window done: clear slot
    input  logic                 gecerli_i,    // slot holds a sample of this window
    input  logic [PIXEL_BIT-1:0] sayi_i,
    input  logic [PIXEL_BIT-1:0] sol_deger_i,  // left neighbour value
    input  logic                 sol_buyuk_i,  // left neighbour shifts right
    output logic [PIXEL_BIT-1:0] deger_o,
    output logic                 buyuk_o,      // this slot shifts right
    output logic [PIXEL_BIT-1:0] yeni_deger_o  // value after insertion, before clear
);
    logic [PIXEL_BIT-1:0] deger_q;
    logic [PIXEL_BIT-1:0] deger_d;

    // Compare, choose keep / take pixel / take left neighbour, then apply clear
    always_comb begin
        buyuk_o      = gecerli_i ? (deger_q > sayi_i) : 1'b1;
        yeni_deger_o = deger_q;
        if (buyuk_o) begin
            yeni_deger_o = sol_buyuk_i ? sol_deger_i : sayi_i;
        end
        deger_d = temizle_i ? '0 : yeni_deger_o;
    end

    // Slot register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deger_q <= '0;
        end else begin
            deger_q <= deger_d;
        end
    end

    assign deger_o = deger_q;
endmodule : siralama_hucresi

// File: rtl/medyan_birimi_seri.sv
// Streaming median of non-overlapping 9-pixel windows. One pixel per clock is
// inserted into a sorted slot chain; on the window's last sample the middle
// slot of the post-insertion array is registered as the median and the chain
// is cleared, so the next window starts on the following edge.
module medyan_birimi_seri
    import medyan_birimi_seri_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    medyan_birimi_seri_if.slave   bus
);
    logic [PIXEL_BIT-1:0] deger [PENCERE];
    logic                 buyuk [PENCERE];
    logic [PIXEL_BIT-1:0] yeni  [PENCERE];

    logic [SAYAC_W-1:0]   sayac_q,  sayac_d;
    logic [PIXEL_BIT-1:0] medyan_q, medyan_d;
    logic                 hazir_q,  hazir_d;
    logic                 son;

    assign son = (sayac_q == SAYAC_W'(PENCERE - 1));

    // Sorted slot chain; slot 0 has no left neighbour
    for (genvar i = 0; i < PENCERE; i++) begin : g_hucre
        logic [PIXEL_BIT-1:0] sol_deger;
        logic                 sol_buyuk;
        if (i == 0) begin : g_ilk
            assign sol_deger = '0;
            assign sol_buyuk = 1'b0;
        end else begin : g_diger
            assign sol_deger = deger[i-1];
            assign sol_buyuk = buyuk[i-1];
        end

        siralama_hucresi u_hucre (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .temizle_i    (son),
            .gecerli_i    (sayac_q > SAYAC_W'(i)),
            .sayi_i       (bus.sayi_i),
            .sol_deger_i  (sol_deger),
            .sol_buyuk_i  (sol_buyuk),
            .deger_o      (deger[i]),
            .buyuk_o      (buyuk[i]),
            .yeni_deger_o (yeni[i])
        );
    end

    // Sample counter, median capture and ready strobe
    always_comb begin
        sayac_d  = son ? '0 : sayac_q + SAYAC_W'(1);
        medyan_d = son ? yeni[MID] : medyan_q;
        hazir_d  = son;
    end

    // Counter and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sayac_q  <= '0;
            medyan_q <= '0;
            hazir_q  <= 1'b0;
        end else begin
            sayac_q  <= sayac_d;
            medyan_q <= medyan_d;
            hazir_q  <= hazir_d;
        end
    end

    assign bus.medyan_o = medyan_q;
    assign bus.hazir_o  = hazir_q;
endmodule : medyan_birimi_seri

// File: tb/tb_medyan_birimi_seri.sv
// Bench for medyan_birimi_seri: directed windows followed by random windows
// and random resets, every cycle checked against a window-queue median model.
module tb_medyan_birimi_seri;
    localparam int W = 8;
    localparam int N = 9;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    medyan_birimi_seri_if #(.PIXEL_BIT(W)) bus ();

    medyan_birimi_seri dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model state
    logic [W-1:0] win_q[$];
    logic [W-1:0] exp_med;
    logic         exp_hz;
    logic         prev_hz;
    int           checks = 0;
    int           errors = 0;

    // Median by rank: the value with at most N/2 samples below it and at
    // least N/2+1 samples at or below it
    function automatic logic [W-1:0] ref_median(input logic [W-1:0] q[$]);
        for (int c = 0; c < q.size(); c++) begin
            int lt = 0;
            int le = 0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k] <  q[c]) lt++;
                if (q[k] <= q[c]) le++;
            end
            if (lt <= N / 2 && le >= N / 2 + 1) return q[c];
        end
        return '0;
    endfunction

    // One clock: drive on the falling edge, update model, check after rise
    task automatic step(input logic r, input logic [W-1:0] v);
        @(negedge clk);
        rst        = r;
        bus.sayi_i = r ? 'x : v;
        @(posedge clk);
        #1;
        if (r) begin
            win_q.delete();
            exp_med = '0;
            exp_hz  = 1'b0;
        end else begin
            win_q.push_back(v);
            exp_hz = 1'b0;
            if (win_q.size() == N) begin
                exp_med = ref_median(win_q);
                exp_hz  = 1'b1;
                win_q.delete();
            end
        end
        checks++;
        assert (bus.hazir_o === exp_hz) else begin
            errors++;
            $error("FAIL hazir obs=%0b exp=%0b t=%0t", bus.hazir_o, exp_hz, $time);
        end
        checks++;
        assert (bus.medyan_o === exp_med) else begin
            errors++;
            $error("FAIL medyan obs=%0d exp=%0d t=%0t", bus.medyan_o, exp_med, $time);
        end
        checks++;
        assert (!(prev_hz === 1'b1 && bus.hazir_o === 1'b1)) else begin
            errors++;
            $error("FAIL hazir_double obs=%0b exp=0 t=%0t", bus.hazir_o, $time);
        end
        prev_hz = bus.hazir_o;
    endtask

    task automatic run_window(input logic [W-1:0] w[N]);
        for (int i = 0; i < N; i++) step(1'b0, w[i]);
    endtask

    // Stimulus
    initial begin
        logic [W-1:0] w[N];
        int hi;
        exp_med    = '0;
        exp_hz     = 1'b0;
        prev_hz    = 1'b0;
        bus.sayi_i = 'x;

        // Reset held for 4 cycles
        for (int i = 0; i < 4; i++) step(1'b1, '0);

        // Directed windows, back-to-back
        w = '{7, 7, 1, 1, 1, 2, 2, 9, 8};            run_window(w);
        w = '{5, 5, 5, 5, 5, 5, 5, 5, 5};            run_window(w);
        w = '{0, 1, 2, 3, 4, 5, 6, 7, 8};            run_window(w);
        w = '{255, 254, 253, 252, 251, 250, 249, 248, 247}; run_window(w);
        w = '{0, 255, 0, 255, 0, 255, 0, 255, 255};  run_window(w);
        w = '{3, 1, 4, 1, 5, 9, 2, 6, 5};            run_window(w);
        w = '{200, 200, 200, 200, 200, 200, 200, 200, 200}; run_window(w);

        // Reset mid-window, then a fresh window
        for (int i = 0; i < 5; i++) step(1'b0, 8'd100);
        step(1'b1, '0);
        w = '{10, 11, 12, 13, 14, 15, 16, 17, 18};   run_window(w);

        // Reset on the edge of what would be the 9th sample
        for (int i = 0; i < 8; i++) step(1'b0, 8'd77);
        step(1'b1, '0);

        // Random windows with duplicates and occasional resets
        for (int n = 0; n < 40; n++) begin
            hi = (n % 2 == 0) ? 7 : 255;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 60) == 0) step(1'b1, '0);
                else step(1'b0, W'($urandom_range(0, hi)));
            end
        end
        for (int i = 0; i < 2 * N; i++) step(1'b0, W'($urandom_range(0, 255)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule : tb_medyan_birimi_seri
